// File: rtl/lsu_ctrl32.sv
// Load/store controller for a word-organised RAM with no byte enables.
// Sub-word loads are extracted and extended; sub-word stores are done as read-modify-write.
module lsu_ctrl32 #(
  parameter int unsigned MEM_BYTES = 65536
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_Memwrite,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {IDLE, LOAD, STORE, RMW_RD, RMW_WR, DONE} state_t;

  state_t      state, state_nxt;
  logic        err_q, sx_q;
  logic [1:0]  size_q, off_q;
  logic [15:0] wdata_q;
  logic        req_err;
  logic [4:0]  sh;
  logic [31:0] lane, load_val, lane_mask, merged;

  assign req_err = (size == 2'b11) ||
                   (size == 2'b01 && addr[0]) ||
                   (size == 2'b10 && addr[1:0] != 2'b00) ||
                   (addr >= 32'(MEM_BYTES));

  assign sh   = {off_q, 3'b000};
  assign lane = mem_read_data >> sh;

  always_comb begin
    load_val = mem_read_data;
    case (size_q)
      2'b00:   load_val = {{24{sx_q & lane[7]}}, lane[7:0]};
      2'b01:   load_val = {{16{sx_q & lane[15]}}, lane[15:0]};
      default: load_val = mem_read_data;
    endcase
  end

  // Only the addressed lane(s) of the fetched word are replaced.
  always_comb begin
    lane_mask = (size_q == 2'b01) ? (32'h0000_FFFF << sh) : (32'h0000_00FF << sh);
    merged    = (mem_read_data & ~lane_mask) | (({16'h0, wdata_q} << sh) & lane_mask);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (req_err)             state_nxt = DONE;
          else if (!we)            state_nxt = LOAD;
          else if (size == 2'b10)  state_nxt = STORE;
          else                     state_nxt = RMW_RD;
        end
      end
      LOAD:    state_nxt = DONE;
      STORE:   state_nxt = DONE;
      RMW_RD:  state_nxt = RMW_WR;
      RMW_WR:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      err_q          <= 1'b0;
      sx_q           <= 1'b0;
      size_q         <= 2'b00;
      off_q          <= 2'b00;
      wdata_q        <= 16'h0;
      rdata          <= 32'h0;
      mem_address    <= 32'h0;
      mem_write_data <= 32'h0;
      mem_Memwrite   <= 1'b0;
    end else begin
      state        <= state_nxt;
      // Registered from next state so the strobe is one clean cycle long.
      mem_Memwrite <= (state_nxt == STORE) || (state_nxt == RMW_WR);
      case (state)
        IDLE: begin
          if (req) begin
            err_q   <= req_err;
            sx_q    <= sign_ext;
            size_q  <= size;
            off_q   <= addr[1:0];
            wdata_q <= wdata[15:0];
            if (!req_err) begin
              mem_address <= {addr[31:2], 2'b00};
              if (we && size == 2'b10) mem_write_data <= wdata;
            end
          end
        end
        LOAD:    rdata          <= load_val;
        RMW_RD:  mem_write_data <= merged;
        default: ;
      endcase
    end
  end

  assign done = (state == DONE);
  assign err  = done & err_q;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_lsu_ctrl32.sv
// Self-checking bench for lsu_ctrl32: falling-edge RAM model, transaction-level
// reference model checked every cycle, directed literal checks and random traffic.
module tb_lsu_ctrl32;

  logic        clock = 1'b0, reset = 1'b1;
  logic        req = 1'b0, we = 1'b0, sign_ext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic [31:0] rdata, mem_address, mem_write_data, mem_read_data;
  logic        done, err, busy, mem_Memwrite;

  logic [31:0] ram     [256];
  logic [31:0] ref_mem [256];
  int checks = 0, failures = 0, wr_cnt = 0;

  lsu_ctrl32 #(.MEM_BYTES(65536)) dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .rdata(rdata),
    .done(done), .err(err), .busy(busy), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_Memwrite(mem_Memwrite),
    .mem_read_data(mem_read_data)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] init_word(int i);
    if (i == 4) return 32'h8899AABB;
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Load result from plain arithmetic on the word value.
  function automatic logic [31:0] ld_val(logic [31:0] w, logic [1:0] sz, logic sx, logic [1:0] off);
    logic [31:0] v;
    v = w >> (8 * off);
    if (sz == 2'd0) begin
      v = v & 32'hFF;
      if (sx && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 2'd1) begin
      v = v & 32'hFFFF;
      if (sx && v >= 32'd32768) v = v - 32'd65536;
    end else v = w;
    return v;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] w, logic [1:0] sz, logic [1:0] off, logic [31:0] d);
    logic [7:0] b [4];
    for (int k = 0; k < 4; k++) b[k] = w[8*k +: 8];
    b[off] = d[7:0];
    if (sz == 2'd1) b[off + 2'd1] = d[15:8];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // RAM: consumes address/data/write at the falling edge.
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = init_word(i);
    mem_read_data = 32'h0;
    forever begin
      @(negedge clock);
      if (mem_Memwrite) begin
        ram[mem_address[9:2]] = mem_write_data;
        wr_cnt++;
      end
      mem_read_data = ram[mem_address[9:2]];
    end
  end

  // Reference model: one transaction in flight, checked every cycle.
  initial begin
    logic        m_active, m_we, m_sx, m_err, exp_done, exp_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata, w;
    logic [7:0]  idx;
    int          m_cnt;
    m_active = 0; m_we = 0; m_sx = 0; m_err = 0; m_size = 0;
    m_addr = 0; m_wdata = 0; m_rdata = 0; m_cnt = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    forever begin
      @(posedge clock);
      if (!reset) begin
        if (m_active) begin
          if (m_cnt == 0) m_active = 0;
          else m_cnt--;
        end else if (req) begin
          m_we = we; m_size = size; m_sx = sign_ext; m_addr = addr; m_wdata = wdata;
          m_err = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
                  (size == 2'd2 && addr[1:0] != 2'd0) || (addr >= 32'd65536);
          m_cnt = m_err ? 0 : ((we && size != 2'd2) ? 2 : 1);
          m_active = 1;
        end
      end
      #2;
      if (reset) begin
        m_active = 0;
        m_rdata  = 32'h0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_memwrite", mem_Memwrite, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_write_data", mem_write_data, 0);
      end else begin
        idx      = m_addr[9:2];
        exp_done = m_active && m_cnt == 0;
        exp_wr   = m_active && !m_err && m_we && m_cnt == 1;
        if (exp_done && !m_err && !m_we) m_rdata = ld_val(ref_mem[idx], m_size, m_sx, m_addr[1:0]);
        chk("busy", busy, m_active);
        chk("done", done, exp_done);
        chk("err", err, exp_done && m_err);
        chk("rdata", rdata, m_rdata);
        chk("memwrite", mem_Memwrite, exp_wr);
        if (exp_wr) begin
          w = (m_size == 2'd2) ? m_wdata : merge(ref_mem[idx], m_size, m_addr[1:0], m_wdata);
          chk("wr_address", mem_address, {m_addr[31:2], 2'b00});
          chk("wr_data", mem_write_data, w);
          ref_mem[idx] = w;
        end
        if (m_active && !m_err && !m_we && m_cnt == 1)
          chk("rd_address", mem_address, {m_addr[31:2], 2'b00});
      end
    end
  end

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic e);
    @(negedge clock);
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
    @(posedge clock);
    #1 req = 1'b0;
    lat = 1;
    while (!done && lat < 10) begin
      @(posedge clock);
      #1;
      lat++;
    end
    e = err;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done expected done within 10 cycles at %0t", $time);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    int   lat, w0;
    logic e;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    do_req(0, 2'd0, 1, 32'h13, 0, lat, e);
    chk("lb_rdata", rdata, 32'hFFFFFF88);
    chk("lb_latency", lat, 2);
    do_req(0, 2'd0, 0, 32'h13, 0, lat, e);
    chk("lbu_rdata", rdata, 32'h00000088);
    do_req(0, 2'd1, 1, 32'h12, 0, lat, e);
    chk("lh_rdata", rdata, 32'hFFFF8899);
    do_req(0, 2'd1, 0, 32'h10, 0, lat, e);
    chk("lhu_rdata", rdata, 32'h0000AABB);

    w0 = wr_cnt;
    do_req(1, 2'd0, 0, 32'h11, 32'h000000CC, lat, e);
    chk("sb_latency", lat, 3);
    chk("sb_write_pulses", wr_cnt - w0, 1);
    chk("sb_ram", ram[4], 32'h8899CCBB);

    w0 = wr_cnt;
    do_req(1, 2'd2, 0, 32'h20, 32'h12345678, lat, e);
    chk("sw_latency", lat, 2);
    chk("sw_write_pulses", wr_cnt - w0, 1);
    do_req(0, 2'd2, 0, 32'h20, 0, lat, e);
    chk("lw_rdata", rdata, 32'h12345678);

    w0 = wr_cnt;
    do_req(0, 2'd2, 0, 32'h22, 0, lat, e);
    chk("err_lw_mis_lat", lat, 1);  chk("err_lw_mis_err", e, 1);
    do_req(1, 2'd1, 0, 32'h01, 32'hFFFF, lat, e);
    chk("err_sh_mis_lat", lat, 1);  chk("err_sh_mis_err", e, 1);
    do_req(0, 2'd3, 0, 32'h10, 0, lat, e);
    chk("err_size_lat", lat, 1);    chk("err_size_err", e, 1);
    do_req(0, 2'd2, 0, 32'h10000, 0, lat, e);
    chk("err_range_lat", lat, 1);   chk("err_range_err", e, 1);
    chk("err_no_writes", wr_cnt - w0, 0);
    chk("err_rdata_kept", rdata, 32'h12345678);

    // Reset during the write cycle of a read-modify-write.
    @(negedge clock);
    req = 1'b1; we = 1'b1; size = 2'd0; sign_ext = 1'b0; addr = 32'h31; wdata = 32'h77;
    w0 = wr_cnt;
    @(posedge clock);
    #1 req = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("abort_memwrite", mem_Memwrite, 0);
    chk("abort_busy", busy, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("abort_ram_kept", ram[12], init_word(12));
    chk("abort_no_writes", wr_cnt - w0, 0);
    do_req(0, 2'd2, 0, 32'h30, 0, lat, e);
    chk("after_abort_lat", lat, 2);
    chk("after_abort_rdata", rdata, init_word(12));

    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      req      = ($urandom % 3) != 0;
      we       = $urandom % 2;
      sign_ext = $urandom % 2;
      size     = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr     = ($urandom % 16 == 0) ? (32'h10000 + $urandom_range(0, 4095)) : $urandom_range(0, 1023);
      wdata    = $urandom;
    end
    @(negedge clock);
    req = 1'b0;
    for (int c = 0; c < 10 && busy; c++) @(negedge clock);
    chk("final_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
